// File: rtl/mux_pkg.sv
// Shared constants for the registered N-channel multiplexer family.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Select width for n channels, never below one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo CHANNELS.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] pos_s;
  logic             hit_s;
  logic             found_s;

  // The wrap is an explicit subtract so non-power-of-two channel counts work.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    pos_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum_s     = {1'b0, ptr} + (SEL_W+1)'(k);
      sum_s     = (sum_s >= CH_W) ? (sum_s - CH_W) : sum_s;
      pos_s     = sum_s[SEL_W-1:0];
      hit_s     = !found_s && req[pos_s];
      grant     = hit_s ? (grant | (CHANNELS'(1) << pos_s)) : grant;
      grant_idx = hit_s ? pos_s : grant_idx;
      found_s   = found_s | hit_s;
    end
  end

endmodule

// File: rtl/mux_rr.sv
// N-channel registered multiplexer with fixed-select or round-robin arbitration.
module mux_rr
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int MODE       = MODE_RR,
  parameter int SEL_W      = sel_w(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  input  logic [SEL_W-1:0]               sel,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]               out_chan,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_chan_q, out_chan_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  logic [CHANNELS-1:0]   grant_s;
  logic [SEL_W-1:0]      grant_idx_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  load_s;
  logic                  any_grant_s;

  if (MODE == MODE_RR) begin : g_rr
    logic sel_unused_s;
    assign sel_unused_s = ^sel;

    rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
    ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
    );
  end else begin : g_fixed
    logic ptr_unused_s;
    assign ptr_unused_s = ^ptr_q;

    // An out-of-range sel matches no channel, so it yields no grant.
    always_comb begin
      grant_s     = '0;
      grant_idx_s = sel;
      for (int i = 0; i < CHANNELS; i++) begin
        grant_s[i] = in_valid[i] && (sel == SEL_W'(i));
      end
    end
  end

  assign load_s      = !out_valid_q || out_ready;
  assign any_grant_s = |grant_s;
  assign in_ready    = rst ? '0 : (grant_s & {CHANNELS{load_s}});

  // One-hot grant makes an AND-OR data select sufficient.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data_s = sel_data_s | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_s && any_grant_s) begin
      out_data_d  = sel_data_s;
      out_chan_d  = grant_idx_s;
      out_valid_d = 1'b1;
      ptr_d       = (grant_idx_s == LAST_CH) ? '0 : (grant_idx_s + SEL_W'(1));
    end else if (load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr.sv
// Self-checking bench for mux_rr: fixed and round-robin modes, 4 and 3 channels.
module tb_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // a: MODE=0, CHANNELS=4
  logic [31:0] a_in_data;  logic [3:0] a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_chan; logic [7:0] a_out_data; logic a_out_valid, a_out_ready;
  // b: MODE=1, CHANNELS=4
  logic [31:0] b_in_data;  logic [3:0] b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_chan; logic [7:0] b_out_data; logic b_out_valid, b_out_ready;
  // c: MODE=1, CHANNELS=3
  logic [23:0] c_in_data;  logic [2:0] c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_chan; logic [7:0] c_out_data; logic c_out_valid, c_out_ready;
  // d: MODE=0, CHANNELS=3
  logic [23:0] d_in_data;  logic [2:0] d_in_valid, d_in_ready;
  logic [1:0]  d_sel, d_out_chan; logic [7:0] d_out_data; logic d_out_valid, d_out_ready;

  mux_rr #(.DATA_WIDTH(8), .CHANNELS(4), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid),
    .out_ready(a_out_ready));
  mux_rr #(.DATA_WIDTH(8), .CHANNELS(4), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready));
  mux_rr #(.DATA_WIDTH(8), .CHANNELS(3), .MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .out_data(c_out_data), .out_chan(c_out_chan), .out_valid(c_out_valid),
    .out_ready(c_out_ready));
  mux_rr #(.DATA_WIDTH(8), .CHANNELS(3), .MODE(0)) dut_d (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .sel(d_sel), .out_data(d_out_data), .out_chan(d_out_chan), .out_valid(d_out_valid),
    .out_ready(d_out_ready));

  // Reference state for dut_b: the output slot and the next-priority channel.
  int m_ptr, m_chan, m_valid;
  int m_data;

  task automatic model_b_reset();
    m_ptr = 0; m_chan = 0; m_valid = 0; m_data = 0;
  endtask

  // One dut_b cycle from a negedge: check in_ready, clock, check outputs.
  task automatic step_b(input string tag);
    int g;
    bit ld;
    logic [3:0] exp_rdy;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && b_in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    ld = (m_valid == 0) || b_out_ready;
    exp_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
    #1;
    chk_cnt++;
    if (b_in_ready !== exp_rdy)
      $display("FAIL %s in_ready: got %b want %b", tag, b_in_ready, exp_rdy);
    else pass_cnt++;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_data = int'(b_in_data[g*8 +: 8]); m_chan = g; m_valid = 1; m_ptr = (g + 1) % 4;
      end else m_valid = 0;
    end
    @(negedge clk);
    chk_cnt++;
    if (b_out_valid !== m_valid[0] || b_out_data !== m_data[7:0] || b_out_chan !== m_chan[1:0])
      $display("FAIL %s out: got v=%b d=%h c=%0d want v=%0d d=%h c=%0d", tag,
               b_out_valid, b_out_data, b_out_chan, m_valid, m_data[7:0], m_chan);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 4'b1111; b_sel = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;
    d_in_data = '0; d_in_valid = '0; d_sel = '0; d_out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({a_out_valid, b_out_valid, c_out_valid, d_out_valid} !== 4'b0000 ||
        b_out_data !== 8'h00 || b_out_chan !== 2'd0 || a_out_data !== 8'h00)
      $display("FAIL reset_outputs: got bv=%b bd=%h bc=%0d av=%b want zeros",
               b_out_valid, b_out_data, b_out_chan, a_out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (b_in_ready !== 4'b0000)
      $display("FAIL reset_in_ready: got %b want 0000", b_in_ready);
    else pass_cnt++;
    b_in_valid = '0;
    rst = 1'b0;
    model_b_reset();
  endtask

  task automatic test_fixed_sel();
    @(negedge clk);
    a_sel = 2'd2; a_in_valid = 4'b1111; a_in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    chk_cnt++;
    if (a_in_ready !== 4'b0100) $display("FAIL fixed_in_ready: got %b want 0100", a_in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (a_out_data !== 8'hA5 || a_out_chan !== 2'd2 || a_out_valid !== 1'b1)
      $display("FAIL fixed_out: got d=%h c=%0d v=%b want d=a5 c=2 v=1", a_out_data, a_out_chan, a_out_valid);
    else pass_cnt++;
    // Stall, then change sel: the held word must not move.
    a_out_ready = 1'b0; a_sel = 2'd1;
    #1;
    chk_cnt++;
    if (a_in_ready !== 4'b0000) $display("FAIL fixed_stall_ready: got %b want 0000", a_in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (a_out_data !== 8'hA5 || a_out_chan !== 2'd2 || a_out_valid !== 1'b1)
      $display("FAIL fixed_stall_hold: got d=%h c=%0d v=%b want d=a5 c=2 v=1", a_out_data, a_out_chan, a_out_valid);
    else pass_cnt++;
    a_out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (a_in_ready !== 4'b0010) $display("FAIL fixed_newsel_ready: got %b want 0010", a_in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (a_out_data !== 8'h22 || a_out_chan !== 2'd1 || a_out_valid !== 1'b1)
      $display("FAIL fixed_newsel_out: got d=%h c=%0d v=%b want d=22 c=1 v=1", a_out_data, a_out_chan, a_out_valid);
    else pass_cnt++;
    a_in_valid = '0;
  endtask

  task automatic test_rr_all();
    logic [7:0] exp_d;
    @(negedge clk);
    b_in_valid = 4'b1111; b_out_ready = 1'b1; b_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      step_b("rr_all");
      exp_d = 8'h10 + 8'(i % 4);
      chk_cnt++;
      if (b_out_chan !== 2'(i % 4) || b_out_data !== exp_d)
        $display("FAIL rr_all_seq[%0d]: got c=%0d d=%h want c=%0d d=%h", i, b_out_chan, b_out_data, i % 4, exp_d);
      else pass_cnt++;
    end
    b_in_valid = '0;
    step_b("rr_all_drain");
  endtask

  task automatic test_rr_wrap();
    int exp_c [4] = '{3, 0, 3, 0};
    // ptr is 1 after the previous test ended on channel 0.
    b_in_valid = 4'b1001; b_in_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
    for (int i = 0; i < 4; i++) begin
      step_b("rr_wrap");
      chk_cnt++;
      if (b_out_chan !== exp_c[i][1:0])
        $display("FAIL rr_wrap_seq[%0d]: got c=%0d want c=%0d", i, b_out_chan, exp_c[i]);
      else pass_cnt++;
    end
    b_in_valid = '0;
    step_b("rr_wrap_drain");
  endtask

  task automatic test_backpressure();
    b_in_valid = 4'b0010; b_in_data = {8'h00, 8'h00, 8'h3C, 8'h00}; b_out_ready = 1'b1;
    step_b("bp_load");
    b_in_valid = 4'b1111; b_in_data = {8'h77, 8'h66, 8'h55, 8'h44}; b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_b("bp_stall");
      chk_cnt++;
      if (b_out_data !== 8'h3C || b_in_ready !== 4'b0000)
        $display("FAIL bp_hold[%0d]: got d=%h rdy=%b want d=3c rdy=0000", i, b_out_data, b_in_ready);
      else pass_cnt++;
    end
    b_out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (b_in_ready !== 4'b0100)
      $display("FAIL bp_release_ready: got %b want 0100", b_in_ready);
    else pass_cnt++;
    step_b("bp_release");
    chk_cnt++;
    if (b_out_valid !== 1'b1 || b_out_data !== 8'h66)
      $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=66", b_out_valid, b_out_data);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      b_in_valid  = 4'($urandom);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 3) != 0);
      step_b("random");
    end
    b_out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    b_in_valid = 4'b0100; b_in_data = {8'h00, 8'h9E, 8'h00, 8'h00}; b_out_ready = 1'b1;
    step_b("rms_load");
    b_out_ready = 1'b0;
    step_b("rms_stall");
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_chan !== 2'd0)
      $display("FAIL reset_mid_stall: got v=%b d=%h c=%0d want v=0 d=00 c=0", b_out_valid, b_out_data, b_out_chan);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    model_b_reset();
    b_in_valid = 4'b1111; b_in_data = {8'h83, 8'h82, 8'h81, 8'h80}; b_out_ready = 1'b1;
    step_b("rms_after");
    chk_cnt++;
    if (b_out_chan !== 2'd0 || b_out_data !== 8'h80)
      $display("FAIL reset_first_grant: got c=%0d d=%h want c=0 d=80", b_out_chan, b_out_data);
    else pass_cnt++;
    b_in_valid = '0;
  endtask

  task automatic test_three_channels();
    logic [7:0] exp_d;
    @(negedge clk);
    c_in_valid = 3'b111; c_in_data = {8'h22, 8'h21, 8'h20}; c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_d = 8'h20 + 8'(i % 3);
      chk_cnt++;
      if (c_out_chan !== 2'(i % 3) || c_out_data !== exp_d || c_out_valid !== 1'b1)
        $display("FAIL c3_rr_seq[%0d]: got c=%0d d=%h v=%b want c=%0d d=%h v=1",
                 i, c_out_chan, c_out_data, c_out_valid, i % 3, exp_d);
      else pass_cnt++;
      chk_cnt++;
      if (dut_c.ptr_q > 2'd2) $display("FAIL c3_ptr_range[%0d]: got %0d want <=2", i, dut_c.ptr_q);
      else pass_cnt++;
    end
    c_in_valid = '0;
    // Fixed mode with an out-of-range select.
    d_in_valid = 3'b111; d_in_data = {8'h52, 8'h51, 8'h50}; d_sel = 2'd0; d_out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (d_out_valid !== 1'b1 || d_out_chan !== 2'd0 || d_out_data !== 8'h50)
      $display("FAIL c3_fixed_sel0: got v=%b c=%0d d=%h want v=1 c=0 d=50", d_out_valid, d_out_chan, d_out_data);
    else pass_cnt++;
    d_sel = 2'd3;
    #1;
    chk_cnt++;
    if (d_in_ready !== 3'b000) $display("FAIL c3_fixed_sel3_ready: got %b want 000", d_in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (d_out_valid !== 1'b0) $display("FAIL c3_fixed_sel3_valid: got %b want 0", d_out_valid);
    else pass_cnt++;
    d_in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fixed_sel();
    test_rr_all();
    test_rr_wrap();
    test_backpressure();
    test_random();
    test_reset_mid_stall();
    test_three_channels();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
